// File: rtl/mag_power_ctrl.sv
// Magnetron power controller: synchronised front-panel inputs, IDLE/COOK/PAUSE
// state machine with pause/resume, and duty-cycled magnetron enable per power period.
module mag_power_ctrl #(
   parameter int PWR_W    = 4,
   parameter int PERIOD   = 10,
   parameter int TICK_DIV = 1000
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             startn,
   input  logic             stopn,
   input  logic             clearn,
   input  logic             door_closed,
   input  logic             timer_done,
   input  logic [PWR_W-1:0] power_level,
   output logic             mag_on,
   output logic             cooking,
   output logic             paused,
   output logic             done_pulse
);

   localparam int LVL_W = $clog2(PERIOD + 1);
   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {S_IDLE, S_COOK, S_PAUSE} state_t;

   function automatic logic [LVL_W-1:0] sat_level(input logic [PWR_W-1:0] v);
      if (int'(v) > PERIOD) return LVL_W'(PERIOD);
      return LVL_W'(v);
   endfunction

   logic r_startn_p0, r_startn_p1, r_startn_p2;
   logic r_stopn_p0,  r_stopn_p1,  r_stopn_p2;
   logic r_clearn_p0, r_clearn_p1;
   logic r_door_p0,   r_door_p1;
   logic r_timer_p0,  r_timer_p1;

   state_t           r_state;
   logic [PRE_W-1:0] r_pre;
   logic [LVL_W-1:0] r_phase;
   logic [LVL_W-1:0] r_level;

   logic             w_start_ev, w_stop_ev, w_clear_lv, w_door_open, w_timer;
   logic [LVL_W-1:0] w_level_in;
   state_t           w_next;
   logic             w_done;
   logic             w_entry;
   logic [PRE_W-1:0] w_pre_nxt;
   logic [LVL_W-1:0] w_ph_nxt;
   logic [LVL_W-1:0] w_lvl_nxt;

   // Stage p0/p1: two-flop synchronisers; p2 holds the previous sample for edge detect
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_startn_p0 <= 1'b1;
         r_startn_p1 <= 1'b1;
         r_startn_p2 <= 1'b1;
         r_stopn_p0  <= 1'b1;
         r_stopn_p1  <= 1'b1;
         r_stopn_p2  <= 1'b1;
         r_clearn_p0 <= 1'b1;
         r_clearn_p1 <= 1'b1;
         r_door_p0   <= 1'b0;
         r_door_p1   <= 1'b0;
         r_timer_p0  <= 1'b0;
         r_timer_p1  <= 1'b0;
      end else begin
         r_startn_p0 <= startn;
         r_startn_p1 <= r_startn_p0;
         r_startn_p2 <= r_startn_p1;
         r_stopn_p0  <= stopn;
         r_stopn_p1  <= r_stopn_p0;
         r_stopn_p2  <= r_stopn_p1;
         r_clearn_p0 <= clearn;
         r_clearn_p1 <= r_clearn_p0;
         r_door_p0   <= door_closed;
         r_door_p1   <= r_door_p0;
         r_timer_p0  <= timer_done;
         r_timer_p1  <= r_timer_p0;
      end
   end

   assign w_start_ev  = r_startn_p2 & ~r_startn_p1;
   assign w_stop_ev   = r_stopn_p2 & ~r_stopn_p1;
   assign w_clear_lv  = ~r_clearn_p1;
   assign w_door_open = ~r_door_p1;
   assign w_timer     = r_timer_p1;
   assign w_level_in  = sat_level(power_level);

   // Priority: clear > timer > door open > stop > start
   always_comb begin
      w_next = r_state;
      w_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_clear_lv && !w_timer && !w_door_open && !w_stop_ev &&
                w_start_ev && (w_level_in != '0))
               w_next = S_COOK;
         end
         S_COOK: begin
            if (w_clear_lv) begin
               w_next = S_IDLE;
            end else if (w_timer) begin
               w_next = S_IDLE;
               w_done = 1'b1;
            end else if (w_door_open || w_stop_ev) begin
               w_next = S_PAUSE;
            end
         end
         S_PAUSE: begin
            if (w_clear_lv || w_timer || w_stop_ev)
               w_next = S_IDLE;
            else if (w_start_ev && !w_door_open)
               w_next = S_COOK;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign w_entry = (w_next == S_COOK) && (r_state != S_COOK);

   // Every entry restarts a fresh period with a newly captured level
   always_comb begin
      w_pre_nxt = '0;
      w_ph_nxt  = '0;
      w_lvl_nxt = r_level;
      if (w_entry) begin
         w_lvl_nxt = w_level_in;
      end else if (w_next == S_COOK) begin
         if (r_pre == PRE_W'(TICK_DIV - 1)) begin
            w_pre_nxt = '0;
            w_ph_nxt  = (r_phase == LVL_W'(PERIOD - 1)) ? '0 : r_phase + LVL_W'(1);
         end else begin
            w_pre_nxt = r_pre + PRE_W'(1);
            w_ph_nxt  = r_phase;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= S_IDLE;
         r_pre      <= '0;
         r_phase    <= '0;
         r_level    <= '0;
         mag_on     <= 1'b0;
         cooking    <= 1'b0;
         paused     <= 1'b0;
         done_pulse <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_pre      <= w_pre_nxt;
         r_phase    <= w_ph_nxt;
         r_level    <= w_lvl_nxt;
         mag_on     <= (w_next == S_COOK) && (w_ph_nxt < w_lvl_nxt);
         cooking    <= (w_next == S_COOK);
         paused     <= (w_next == S_PAUSE);
         done_pulse <= w_done;
      end
   end

endmodule

// File: tb/tb_mag_power_ctrl.sv
// Scenario bench for mag_power_ctrl: randomized levels and timings checked
// against an arithmetic duty model and the documented state rules.
module tb_mag_power_ctrl;

   localparam int PWR_W = 4;
   localparam int PER   = 10;
   localparam int TDIV  = 4;

   logic             clk = 1'b0;
   logic             resetn, startn, stopn, clearn, door_closed, timer_done;
   logic [PWR_W-1:0] power_level;
   logic             mag_on, cooking, paused, done_pulse;

   int n_cmp = 0;
   int n_bad = 0;

   mag_power_ctrl #(.PWR_W(PWR_W), .PERIOD(PER), .TICK_DIV(TDIV)) dut (
      .clk(clk), .resetn(resetn), .startn(startn), .stopn(stopn),
      .clearn(clearn), .door_closed(door_closed), .timer_done(timer_done),
      .power_level(power_level), .mag_on(mag_on), .cooking(cooking),
      .paused(paused), .done_pulse(done_pulse)
   );

   always #5 clk = ~clk;

   // Magnetron is on while the tick index within the period is below the level
   function automatic logic exp_mag(input int k, input int lvl);
      int eff;
      eff = (lvl > PER) ? PER : lvl;
      return ((k / TDIV) % PER) < eff;
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press_start();
      startn = 1'b0;
      step(3);
      startn = 1'b1;
   endtask

   task automatic press_stop();
      stopn = 1'b0;
      step(3);
      stopn = 1'b1;
   endtask

   task automatic go_idle();
      clearn = 1'b0;
      step(3);
      clearn = 1'b1;
      step(4);
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      #3;
      n_cmp++;
      if ({mag_on, cooking, paused, done_pulse} !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_init: outs=%b expected 0000", {mag_on, cooking, paused, done_pulse});
      end
      resetn = 1'b1;
      step(5);
      power_level = 4'(5);
      press_start();
      n_cmp++;
      if ({cooking, paused, mag_on} !== 3'b101) begin
         n_bad++;
         $display("FAIL reset_pre_cook: cook/pause/mag=%b expected 101", {cooking, paused, mag_on});
      end
      step(2);
      #2;
      resetn = 1'b0;
      #1;
      n_cmp++;
      if ({mag_on, cooking, paused, done_pulse} !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_async: outs=%b expected 0000", {mag_on, cooking, paused, done_pulse});
      end
      #2;
      resetn = 1'b1;
      step(1);
      for (int i = 0; i < 20; i++) begin
         n_cmp++;
         if ({mag_on, cooking, paused} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_after cyc=%0d: outs=%b expected 000", i, {mag_on, cooking, paused});
         end
         step(1);
      end
   endtask

   task automatic test_duty();
      int lvl;
      for (int r = 0; r < 5; r++) begin
         case (r)
            0, 1, 2: lvl = int'($urandom_range(1, 9));
            3:       lvl = PER;
            default: lvl = int'($urandom_range(11, 15));
         endcase
         power_level = 4'(lvl);
         press_start();
         n_cmp++;
         if (cooking !== 1'b1) begin
            n_bad++;
            $display("FAIL duty_enter lvl=%0d: cooking=%b expected 1", lvl, cooking);
         end
         for (int k = 0; k < 90; k++) begin
            n_cmp++;
            if (mag_on !== exp_mag(k, lvl)) begin
               n_bad++;
               $display("FAIL duty lvl=%0d k=%0d: mag_on=%b expected %b", lvl, k, mag_on, exp_mag(k, lvl));
            end
            step(1);
         end
         go_idle();
      end
   endtask

   task automatic test_door();
      int lvl, m;
      lvl = int'($urandom_range(1, 9));
      m = int'($urandom_range(5, 30));
      power_level = 4'(lvl);
      press_start();
      for (int k = 0; k < m; k++) begin
         n_cmp++;
         if (mag_on !== exp_mag(k, lvl)) begin
            n_bad++;
            $display("FAIL door_pre k=%0d: mag_on=%b expected %b", k, mag_on, exp_mag(k, lvl));
         end
         step(1);
      end
      door_closed = 1'b0;
      step(3);
      n_cmp++;
      if ({cooking, paused, mag_on} !== 3'b010) begin
         n_bad++;
         $display("FAIL door_open: cook/pause/mag=%b expected 010", {cooking, paused, mag_on});
      end
      press_start();
      step(2);
      n_cmp++;
      if ({cooking, paused, mag_on} !== 3'b010) begin
         n_bad++;
         $display("FAIL door_start_open: cook/pause/mag=%b expected 010", {cooking, paused, mag_on});
      end
      door_closed = 1'b1;
      step(4);
      press_start();
      for (int k = 0; k < 40; k++) begin
         n_cmp++;
         if ({cooking, mag_on} !== {1'b1, exp_mag(k, lvl)}) begin
            n_bad++;
            $display("FAIL door_resume k=%0d: cook/mag=%b expected %b", k, {cooking, mag_on}, {1'b1, exp_mag(k, lvl)});
         end
         step(1);
      end
      go_idle();
   endtask

   task automatic test_stop();
      power_level = 4'($urandom_range(1, 10));
      press_start();
      step(int'($urandom_range(1, 20)));
      stopn = 1'b0;
      step(3);
      for (int i = 0; i < 97; i++) begin
         n_cmp++;
         if ({cooking, paused, mag_on} !== 3'b010) begin
            n_bad++;
            $display("FAIL stop_hold cyc=%0d: cook/pause/mag=%b expected 010", i, {cooking, paused, mag_on});
         end
         step(1);
      end
      stopn = 1'b1;
      step(4);
      press_stop();
      n_cmp++;
      if ({cooking, paused, mag_on} !== 3'b000) begin
         n_bad++;
         $display("FAIL stop_cancel: cook/pause/mag=%b expected 000", {cooking, paused, mag_on});
      end
      step(4);
      press_start();
      step(4);
      press_stop();
      timer_done = 1'b1;
      step(3);
      n_cmp++;
      if ({cooking, paused, done_pulse} !== 3'b000) begin
         n_bad++;
         $display("FAIL pause_timer: cook/pause/done=%b expected 000", {cooking, paused, done_pulse});
      end
      step(1);
      n_cmp++;
      if (done_pulse !== 1'b0) begin
         n_bad++;
         $display("FAIL pause_timer_done: done_pulse=%b expected 0", done_pulse);
      end
      timer_done = 1'b0;
      step(4);
   endtask

   task automatic test_timer();
      power_level = 4'($urandom_range(1, 10));
      press_start();
      step(int'($urandom_range(1, 30)));
      timer_done = 1'b1;
      step(3);
      n_cmp++;
      if ({cooking, paused, mag_on, done_pulse} !== 4'b0001) begin
         n_bad++;
         $display("FAIL timer_end: cook/pause/mag/done=%b expected 0001", {cooking, paused, mag_on, done_pulse});
      end
      step(1);
      n_cmp++;
      if (done_pulse !== 1'b0) begin
         n_bad++;
         $display("FAIL timer_pulse_width: done_pulse=%b expected 0", done_pulse);
      end
      timer_done = 1'b0;
      step(4);
      press_start();
      step(int'($urandom_range(1, 30)));
      timer_done  = 1'b1;
      clearn      = 1'b0;
      door_closed = 1'b0;
      step(3);
      n_cmp++;
      if ({cooking, paused, mag_on, done_pulse} !== 4'b0000) begin
         n_bad++;
         $display("FAIL prio_clear: cook/pause/mag/done=%b expected 0000", {cooking, paused, mag_on, done_pulse});
      end
      step(1);
      n_cmp++;
      if (done_pulse !== 1'b0) begin
         n_bad++;
         $display("FAIL prio_clear_next: done_pulse=%b expected 0", done_pulse);
      end
      timer_done  = 1'b0;
      clearn      = 1'b1;
      door_closed = 1'b1;
      step(4);
   endtask

   task automatic test_start_gating();
      for (int g = 0; g < 3; g++) begin
         power_level = (g == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         door_closed = (g != 1);
         timer_done  = (g == 2);
         step(3);
         press_start();
         for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if ({cooking, paused, mag_on} !== 3'b000) begin
               n_bad++;
               $display("FAIL gate%0d cyc=%0d: cook/pause/mag=%b expected 000", g, i, {cooking, paused, mag_on});
            end
            step(1);
         end
         door_closed = 1'b1;
         timer_done  = 1'b0;
         step(4);
      end
      power_level = 4'd3;
      press_start();
      for (int k = 0; k < 80; k++) begin
         if (k == 10) power_level = 4'd7;
         n_cmp++;
         if (mag_on !== exp_mag(k, 3)) begin
            n_bad++;
            $display("FAIL level_hold k=%0d: mag_on=%b expected %b", k, mag_on, exp_mag(k, 3));
         end
         step(1);
      end
      press_stop();
      step(4);
      press_stop();
      step(4);
      press_start();
      for (int k = 0; k < 40; k++) begin
         n_cmp++;
         if (mag_on !== exp_mag(k, 7)) begin
            n_bad++;
            $display("FAIL level_reentry k=%0d: mag_on=%b expected %b", k, mag_on, exp_mag(k, 7));
         end
         step(1);
      end
      go_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn      = 1'b0;
      startn      = 1'b1;
      stopn       = 1'b1;
      clearn      = 1'b1;
      door_closed = 1'b1;
      timer_done  = 1'b0;
      power_level = 4'd3;
      test_reset();
      test_duty();
      test_door();
      test_stop();
      test_timer();
      test_start_gating();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
